imu_fifo_reader: RTL and testbench

//  Read-side controller for the IMU Synchronizer buffer FIFO. Pops 64-bit IMU samples and

---
 rtl/imu_fifo_reader_pkg.sv | 22 ++
 rtl/imu_fifo_reader_if.sv | 22 ++
 rtl/imu_fifo_reader_skid_buf2.sv | 52 +++++
 rtl/imu_fifo_reader.sv | 123 ++++++++++++
 tb/tb_imu_fifo_reader.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/imu_fifo_reader_pkg.sv
// Shared types and helpers for the IMU synchronizer FIFO read path.
// The timestamp occupies the top TS_W bits of each sample.
package imu_sync_pkg;

  typedef enum logic {RUN, FLUSH} rd_state_t;

  localparam int IMU_WIDTH  = 64;
  localparam int IMU_TS_W   = 32;
  localparam int IMU_CNT_W  = 16;
  localparam int IMU_TS_MSB = IMU_WIDTH - 1;
  localparam int IMU_TS_LSB = IMU_WIDTH - IMU_TS_W;

  // Adds inc to a and clamps the result at lim (counter all-ones).
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] inc,
                                          input logic [31:0] lim);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return (sum > {1'b0, lim}) ? lim : sum[31:0];
  endfunction

endpackage

// File: rtl/imu_fifo_reader_if.sv
// FIFO read port plus outgoing sample stream of the IMU FIFO reader.
// master = the reader, slave = FIFO/downstream side.
interface imu_fifo_reader_if #(parameter int WIDTH = 64);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd_en;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data, m_ready,
    output fifo_rd_en, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data, m_ready,
    input  fifo_rd_en, m_valid, m_data
  );

endinterface

// File: rtl/imu_fifo_reader_skid_buf2.sv
// Two-entry in-order output buffer; head is always the oldest entry.
// clear empties the buffer and overrides push/pop.
module imu_skid_buf2
  import imu_sync_pkg::*;
#(
  parameter int WIDTH = IMU_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       occ,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      occ  <= 2'd0;
      head <= '0;
      tail <= '0;
    end else if (clear) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Simultaneous push/pop keeps occupancy; new word lands behind the survivor.
          if (occ == 2'd1) begin
            head <= din;
          end else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/imu_fifo_reader.sv
// Read-side controller for the IMU sync FIFO: absorbs read latency, drops stale
// samples by timestamp age, streams survivors, supports flush and statistics.
//
//   state | meaning
//   RUN   | normal streaming; reads gated by buffer room
//   FLUSH | drain FIFO, discard every returning word, m_valid held low
module imu_fifo_reader
  import imu_sync_pkg::*;
#(
  parameter int WIDTH = IMU_WIDTH,
  parameter int TS_W  = IMU_TS_W,
  parameter int CNT_W = IMU_CNT_W
) (
  input  logic                clk,
  input  logic                rst,
  imu_fifo_reader_if.master   bus,
  input  logic [TS_W-1:0]     ref_time,
  input  logic [TS_W-1:0]     max_age,
  input  logic                drop_en,
  input  logic                flush,
  input  logic                cnt_clr,
  output logic                busy,
  output logic [CNT_W-1:0]    delivered_cnt,
  output logic [CNT_W-1:0]    dropped_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONES = '1;

  rd_state_t       state;
  logic            pend;
  logic            pop;
  logic            push;
  logic            clear;
  logic            rd_en;
  logic            stale;
  logic [1:0]      occ;
  logic [1:0]      drop_n;
  logic [2:0]      fill;
  logic [TS_W-1:0] age;

  // Modular difference handles time-base wrap naturally.
  assign age   = ref_time - bus.fifo_data[WIDTH-1 -: TS_W];
  assign stale = drop_en && (age > max_age);

  assign bus.m_valid    = (occ != 2'd0);
  assign pop            = bus.m_valid && bus.m_ready;
  assign fill           = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
  assign bus.fifo_rd_en = rd_en;

  always_comb begin
    rd_en  = 1'b0;
    push   = 1'b0;
    clear  = 1'b0;
    drop_n = 2'd0;
    case (state)
      RUN: begin
        rd_en = !rst && !bus.fifo_empty && (fill < 3'd2);
        if (flush) begin
          // The handshake this cycle still completes; everything else is discarded.
          clear  = 1'b1;
          drop_n = (occ - {1'b0, pop}) + {1'b0, pend};
        end else begin
          push   = pend && !stale;
          drop_n = {1'b0, pend && stale};
        end
      end
      FLUSH: begin
        rd_en  = !rst && !bus.fifo_empty;
        drop_n = {1'b0, pend};
      end
      default: ;
    endcase
  end

  imu_skid_buf2 #(.WIDTH(WIDTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .push  (push),
    .pop   (pop),
    .din   (bus.fifo_data),
    .occ   (occ),
    .head  (bus.m_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= RUN;
      busy          <= 1'b0;
      pend          <= 1'b0;
      delivered_cnt <= '0;
      dropped_cnt   <= '0;
    end else begin
      pend <= rd_en;
      case (state)
        RUN: begin
          if (flush) begin
            state <= FLUSH;
            busy  <= 1'b1;
          end
        end
        FLUSH: begin
          if (bus.fifo_empty && !pend) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= RUN;
          busy  <= 1'b0;
        end
      endcase
      if (cnt_clr) begin
        delivered_cnt <= '0;
        dropped_cnt   <= '0;
      end else begin
        delivered_cnt <= CNT_W'(sat_add(32'(delivered_cnt), 32'(pop), 32'(CNT_ONES)));
        dropped_cnt   <= CNT_W'(sat_add(32'(dropped_cnt), 32'(drop_n), 32'(CNT_ONES)));
      end
    end
  end

endmodule

// File: tb/tb_imu_fifo_reader.sv
// Directed bench for imu_fifo_reader with a behavioural 1-cycle-latency FIFO.
// Inputs change and outputs are sampled on the falling edge.
module tb_imu_fifo_reader;
  import imu_sync_pkg::*;

  localparam int WIDTH = 64;
  localparam int TS_W  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [TS_W-1:0]  ref_time;
  logic [TS_W-1:0]  max_age;
  logic             drop_en;
  logic             flush;
  logic             cnt_clr;
  logic             busy;
  logic [CNT_W-1:0] delivered_cnt;
  logic [CNT_W-1:0] dropped_cnt;

  int total = 0;
  int bad   = 0;

  logic [63:0] fmem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  imu_fifo_reader_if #(.WIDTH(WIDTH)) bus ();

  imu_fifo_reader #(.WIDTH(WIDTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .ref_time      (ref_time),
    .max_age       (max_age),
    .drop_en       (drop_en),
    .flush         (flush),
    .cnt_clr       (cnt_clr),
    .busy          (busy),
    .delivered_cnt (delivered_cnt),
    .dropped_cnt   (dropped_cnt)
  );

  // FIFO model: registered read data, shares rst with the DUT.
  assign bus.fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (rst) begin
      rd_ptr <= wr_ptr;
    end else if (bus.fifo_rd_en && !bus.fifo_empty) begin
      bus.fifo_data <= fmem[rd_ptr];
      rd_ptr        <= rd_ptr + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] ts, input logic [31:0] pl);
    fmem[wr_ptr] = {ts, pl};
    wr_ptr++;
  endtask

  task automatic clr();
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    chk("clr_deliv", 64'(delivered_cnt), 64'd0);
    chk("clr_drop", 64'(dropped_cnt), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int rd0;
    int idx;
    int n;
    logic [63:0] exp_st [0:2];

    flush = 1'b0; cnt_clr = 1'b0; drop_en = 1'b0;
    ref_time = '0; max_age = '0; bus.m_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_mvalid", 64'(bus.m_valid), 64'd0);
    chk("rst_rden",   64'(bus.fifo_rd_en), 64'd0);
    chk("rst_mdata",  bus.m_data, 64'd0);
    chk("rst_busy",   64'(busy), 64'd0);
    chk("rst_deliv",  64'(delivered_cnt), 64'd0);
    chk("rst_drop",   64'(dropped_cnt), 64'd0);
    rst = 1'b0;

    // Streaming: 8 words, ready held high
    bus.m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(32'(1000 + i), 32'hA000_0000 + 32'(i));
    @(negedge clk);
    chk("stream_lat", 64'(bus.m_valid), 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stream_valid", 64'(bus.m_valid), 64'd1);
      chk("stream_data", bus.m_data, {32'(1000 + i), 32'hA000_0000 + 32'(i)});
    end
    @(negedge clk);
    chk("stream_end", 64'(bus.m_valid), 64'd0);
    chk("stream_cnt", 64'(delivered_cnt), 64'd8);
    clr();

    // Backpressure: ready low for 5 cycles
    bus.m_ready = 1'b0;
    rd0 = rd_ptr;
    for (int i = 0; i < 6; i++) push(32'(2000 + i), 32'hB000_0000 + 32'(i));
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c >= 2) begin
        chk("bp_valid", 64'(bus.m_valid), 64'd1);
        chk("bp_hold", bus.m_data, {32'd2000, 32'hB000_0000});
      end
    end
    chk("bp_reads", 64'(rd_ptr - rd0), 64'd2);
    bus.m_ready = 1'b1;
    idx = 1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        if (idx < 6) chk("bp_data", bus.m_data, {32'(2000 + idx), 32'hB000_0000 + 32'(idx)});
        idx++;
      end
    end
    chk("bp_count", 64'(idx), 64'd6);
    chk("bp_deliv", 64'(delivered_cnt), 64'd6);
    clr();

    // Stale dropping: ages 50, 101, 100, 0 against max_age 100
    drop_en = 1'b1; ref_time = 32'd1000; max_age = 32'd100;
    push(32'd950, 32'hC000_0000);
    push(32'd899, 32'hC000_0001);
    push(32'd900, 32'hC000_0002);
    push(32'd1000, 32'hC000_0003);
    exp_st[0] = {32'd950, 32'hC000_0000};
    exp_st[1] = {32'd900, 32'hC000_0002};
    exp_st[2] = {32'd1000, 32'hC000_0003};
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        if (idx < 3) chk("stale_data", bus.m_data, exp_st[idx]);
        idx++;
      end
    end
    chk("stale_count", 64'(idx), 64'd3);
    chk("stale_drop", 64'(dropped_cnt), 64'd1);
    chk("stale_deliv", 64'(delivered_cnt), 64'd3);
    clr();

    // Wrap: age 21 kept, age 261 dropped
    ref_time = 32'd5;
    push(32'hFFFF_FFF0, 32'hD000_0000);
    push(32'hFFFF_FF00, 32'hD000_0001);
    idx = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.m_valid) begin
        if (idx < 1) chk("wrap_data", bus.m_data, {32'hFFFF_FFF0, 32'hD000_0000});
        idx++;
      end
    end
    chk("wrap_count", 64'(idx), 64'd1);
    chk("wrap_drop", 64'(dropped_cnt), 64'd1);
    clr();

    // Flush with one buffered word and one read in flight, 5 left in FIFO
    drop_en = 1'b0; bus.m_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(32'(3000 + i), 32'hE000_0000 + 32'(i));
    repeat (2) @(negedge clk);
    chk("fla_pre_valid", 64'(bus.m_valid), 64'd1);
    chk("fla_pre_busy", 64'(busy), 64'd0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("fla_busy", 64'(busy), 64'd1);
    chk("fla_mvalid0", 64'(bus.m_valid), 64'd0);
    n = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!busy) break;
      chk("fla_mvalid", 64'(bus.m_valid), 64'd0);
      n++;
    end
    chk("fla_busy_cycles", 64'(n), 64'd7);
    chk("fla_drop", 64'(dropped_cnt), 64'd7);
    chk("fla_deliv", 64'(delivered_cnt), 64'd0);
    chk("fla_fifo_empty", 64'(wr_ptr - rd_ptr), 64'd0);
    chk("fla_post_valid", 64'(bus.m_valid), 64'd0);
    clr();

    // Flush while a handshake completes in the same cycle
    for (int i = 0; i < 3; i++) push(32'(4000 + i), 32'hF000_0000 + 32'(i));
    repeat (3) @(negedge clk);
    chk("flb_head", bus.m_data, {32'd4000, 32'hF000_0000});
    flush = 1'b1; bus.m_ready = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus.m_ready = 1'b0;
    chk("flb_busy", 64'(busy), 64'd1);
    chk("flb_deliv", 64'(delivered_cnt), 64'd1);
    n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
    end
    chk("flb_busy_cycles", 64'(n), 64'd2);
    chk("flb_drop", 64'(dropped_cnt), 64'd2);
    clr();

    // Flush with nothing to drain lasts one cycle
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flc_busy", 64'(busy), 64'd1);
    @(negedge clk);
    chk("flc_done", 64'(busy), 64'd0);
    chk("flc_drop", 64'(dropped_cnt), 64'd0);

    // Saturation: 20 stale drops into a 4-bit counter
    drop_en = 1'b1; ref_time = 32'd1000; max_age = 32'd10; bus.m_ready = 1'b1;
    for (int i = 0; i < 20; i++) push(32'd0, 32'h5000_0000 + 32'(i));
    repeat (26) @(negedge clk);
    chk("sat_drop", 64'(dropped_cnt), 64'd15);
    chk("sat_deliv", 64'(delivered_cnt), 64'd0);
    chk("sat_mvalid", 64'(bus.m_valid), 64'd0);
    clr();

    // cnt_clr held across two drops wins over both increments
    push(32'd0, 32'h6000_0000);
    push(32'd0, 32'h6000_0001);
    cnt_clr = 1'b1;
    repeat (3) @(negedge clk);
    cnt_clr = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_wins", 64'(dropped_cnt), 64'd0);

    // Reset in the middle of a stream
    drop_en = 1'b0;
    for (int i = 0; i < 6; i++) push(32'(5000 + i), 32'h1100_0000 + 32'(i));
    repeat (4) @(negedge clk);
    chk("mid_pre_deliv", 64'(delivered_cnt), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_mvalid", 64'(bus.m_valid), 64'd0);
    chk("mid_rden", 64'(bus.fifo_rd_en), 64'd0);
    chk("mid_mdata", bus.m_data, 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_deliv", 64'(delivered_cnt), 64'd0);
    chk("mid_drop", 64'(dropped_cnt), 64'd0);
    rst = 1'b0;
    push(32'd7777, 32'h7700_0000);
    @(negedge clk);
    chk("post_lat", 64'(bus.m_valid), 64'd0);
    @(negedge clk);
    chk("post_valid", 64'(bus.m_valid), 64'd1);
    chk("post_data", bus.m_data, {32'd7777, 32'h7700_0000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
